// File: rtl/event_stretcher_pkg.sv
// event_stretcher_pkg: shared state encodings and default tick constants
package event_stretcher_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ON   = 2'b01,
      GAP  = 2'b10
   } state_t;
   localparam int DEF_ON_TICKS   = 4;
   localparam int DEF_OFF_TICKS  = 3;
   localparam int DEF_CNT_WIDTH  = 3;
   localparam int DEF_PEND_WIDTH = 2;
endpackage

// File: rtl/event_stretcher_if.sv
// event_stretcher_if: event/tick inputs and LED/status outputs of the stretcher
interface event_stretcher_if #(parameter int PEND_WIDTH = 2);
   logic                  en;
   logic                  in;
   logic                  out;
   logic                  busy;
   logic [PEND_WIDTH-1:0] pending;
   logic                  overflow;
   modport master (output en, in, input out, busy, pending, overflow);
   modport slave  (input en, in, output out, busy, pending, overflow);
endinterface

// File: rtl/d_ff_re.sv
// d_ff_re: register with synchronous active-high reset and enable
module d_ff_re #(parameter int W = 1) (
   input  logic         clk,
   input  logic         r,
   input  logic         e,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // reset wins over enable; enable low holds the value
   always_ff @(posedge clk)
      q <= r ? '0 : e ? d : q;
endmodule

// File: rtl/event_stretcher.sv
// event_stretcher: turns single-cycle event pulses into visible LED blinks
module event_stretcher
   import event_stretcher_pkg::*;
#(
   parameter int ON_TICKS   = DEF_ON_TICKS,
   parameter int OFF_TICKS  = DEF_OFF_TICKS,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int PEND_WIDTH = DEF_PEND_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   event_stretcher_if.slave bus
);
   logic [1:0]            st_q, st_d;
   logic [CNT_WIDTH-1:0]  tm_q, tm_d;
   logic [PEND_WIDTH-1:0] pend_q, pend_d;
   logic                  ovf_q;
   logic                  active, on_end, gap_end, start, tm_e, pend_full;
   assign active    = st_q == ON || st_q == GAP;
   assign on_end    = st_q == ON  && tm_q == CNT_WIDTH'(ON_TICKS - 1);
   assign gap_end   = st_q == GAP && tm_q == CNT_WIDTH'(OFF_TICKS - 1);
   assign start     = st_q == IDLE && pend_q != '0;
   assign pend_full = pend_q == '1;
   // timer only moves on tick strobes while blinking; outside a blink it is forced to zero
   assign tm_e = bus.en || !active;
   // next state and timer; the unused code falls back to IDLE
   always_comb begin
      st_d = start                    ? ON
           : (on_end  && bus.en)      ? GAP
           : (gap_end && bus.en)      ? IDLE
           : (active || st_q == IDLE) ? st_q
           :                            IDLE;
      tm_d = (active && !on_end && !gap_end) ? tm_q + 1'b1 : '0;
   end
   d_ff_re #(.W(2)) u_state (
      .clk (clk),
      .r   (~reset),
      .e   (1'b1),
      .d   (st_d),
      .q   (st_q)
   );
   d_ff_re #(.W(CNT_WIDTH)) u_timer (
      .clk (clk),
      .r   (~reset),
      .e   (tm_e),
      .d   (tm_d),
      .q   (tm_q)
   );
   // saturating queue: an arrival and a blink start in the same cycle cancel out
   always_comb
      pend_d = (bus.in && !start && !pend_full) ? pend_q + 1'b1
             : (!bus.in && start)               ? pend_q - 1'b1
             :                                    pend_q;
   // pending count and sticky drop flag
   always_ff @(posedge clk)
      if (!reset) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_q | (bus.in && !start && pend_full);
      end
   assign bus.out      = st_q == ON;
   assign bus.busy     = st_q != IDLE;
   assign bus.pending  = pend_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_event_stretcher.sv
// tb_event_stretcher: scoreboard bench for event_stretcher with default parameters
module tb_event_stretcher;
   localparam int ONT = 4;
   localparam int OFFT = 3;
   localparam int PMAX = 3;
   typedef struct {
      logic       out;
      logic       busy;
      logic [1:0] pend;
      logic       ovf;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   event_stretcher_if #(.PEND_WIDTH(2)) bus ();
   event_stretcher dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   m_ph = 0;
   int   m_left = 0;
   int   m_pend = 0;
   int   m_ovf = 0;
   int   blinks = 0;
   int   hi_cnt = 0;
   logic prev_out = 1'b0;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, act, exp, $time);
      end
   endtask
   // reference: phases count down remaining ticks rather than counting up
   task automatic model(input logic i, input logic e, input logic r);
      bit   dec;
      exp_t x;
      if (!r) begin
         m_ph = 0; m_left = 0; m_pend = 0; m_ovf = 0;
      end else begin
         dec = (m_ph == 0) && (m_pend != 0);
         if (i && !dec) begin
            if (m_pend == PMAX) m_ovf = 1;
            else m_pend++;
         end else if (!i && dec) m_pend--;
         case (m_ph)
            0: if (dec) begin m_ph = 1; m_left = ONT; end
            1: if (e) begin
                  m_left--;
                  if (m_left == 0) begin m_ph = 2; m_left = OFFT; end
               end
            default: if (e) begin
                  m_left--;
                  if (m_left == 0) m_ph = 0;
               end
         endcase
      end
      x.out = (m_ph == 1);
      x.busy = (m_ph != 0);
      x.pend = 2'(m_pend);
      x.ovf = (m_ovf != 0);
      sb.push_back(x);
   endtask
   task automatic step(input logic i, input logic e, input logic r);
      exp_t x;
      bus.in = i;
      bus.en = e;
      reset = r;
      model(i, e, r);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         x = sb.pop_front();
         check("out", 32'(bus.out), 32'(x.out));
         check("busy", 32'(bus.busy), 32'(x.busy));
         check("pending", 32'(bus.pending), 32'(x.pend));
         check("overflow", 32'(bus.overflow), 32'(x.ovf));
      end
      if (bus.out && !prev_out) blinks++;
      if (bus.out) hi_cnt++;
      prev_out = bus.out;
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1);
   endtask
   initial begin
      bus.in = 1'b0;
      bus.en = 1'b1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("rst_out", 32'(bus.out), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_pend", 32'(bus.pending), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      idle(7);
      blinks = 0; hi_cnt = 0;
      step(1'b1, 1'b1, 1'b1);
      check("single_pend1", 32'(bus.pending), 1);
      check("single_out_lat", 32'(bus.out), 0);
      step(1'b0, 1'b1, 1'b1);
      check("single_out_on", 32'(bus.out), 1);
      idle(20);
      check("single_blinks", blinks, 1);
      check("single_high", hi_cnt, ONT);
      check("single_busy", 32'(bus.busy), 0);
      blinks = 0; hi_cnt = 0;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
      check("b3_pend", 32'(bus.pending), 2);
      idle(40);
      check("b3_blinks", blinks, 3);
      check("b3_high", hi_cnt, 3 * ONT);
      check("b3_ovf", 32'(bus.overflow), 0);
      blinks = 0; hi_cnt = 0;
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1);
      check("b5_pend", 32'(bus.pending), 3);
      check("b5_ovf", 32'(bus.overflow), 1);
      idle(50);
      check("b5_blinks", blinks, 4);
      check("b5_ovf_sticky", 32'(bus.overflow), 1);
      step(1'b0, 1'b1, 1'b0);
      check("ovf_cleared", 32'(bus.overflow), 0);
      idle(2);
      blinks = 0; hi_cnt = 0;
      step(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 80; k++) step(1'b0, (k % 4) == 0, 1'b1);
      check("thr_blinks", blinks, 1);
      check("thr_len_ok", 32'(hi_cnt >= 13 && hi_cnt <= 19), 1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b1);
      check("hold_out", 32'(bus.out), 1);
      idle(20);
      check("hold_drained", 32'(bus.busy), 0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("mid_on", 32'(bus.out), 1);
      check("mid_pend", 32'(bus.pending), 2);
      step(1'b0, 1'b1, 1'b0);
      check("mid_rst_out", 32'(bus.out), 0);
      check("mid_rst_pend", 32'(bus.pending), 0);
      blinks = 0;
      idle(30);
      check("mid_no_blinks", blinks, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/event_stretcher.md
# event_stretcher

Output-side counterpart to the push-button debouncer: converts single-cycle internal event pulses (e.g. a committed instruction, a halt, or a UART byte) into board-LED blinks that a person can see. Each accepted event produces one blink with a guaranteed minimum on-time and minimum off-time. Events that arrive while a blink is in progress are queued in a small saturating counter. The block sits between the pipeline or VGA debug logic and the board LED pins, and shares the debouncer's tick-enable scheme.

## Interface
- `ON_TICKS`, default 4: blink high time, in `en` strobes; must be ≥1 and ≤2^`CNT_WIDTH`.
- `OFF_TICKS`, default 3: forced low gap after each blink, in `en` strobes; same bounds as `ON_TICKS`.
- `CNT_WIDTH`, default 3: width of the tick timer.
- `PEND_WIDTH`, default 2: width of the pending-event counter; maximum queued value is 2^`PEND_WIDTH`−1.
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low; low at a rising edge clears all state.
- `en`, input, 1: tick strobe; the timer advances only when `en`=1.
- `in`, input, 1: event pulse; every cycle with `in`=1 counts as one event.
- `out`, output, 1: LED drive, high during a blink.
- `busy`, output, 1: high whenever the FSM is not IDLE.
- `pending`, output, `PEND_WIDTH`: number of queued events not yet started.
- `overflow`, output, 1: sticky flag, set when an event is dropped; cleared only by reset.

## Operation
- FSM states: IDLE=2'b00, ON=2'b01, GAP=2'b10. Code 2'b11 is illegal and returns to IDLE with `out`=0.
- IDLE:
  - `out`=0, timer held at 0.
  - If `pending`≠0, go to ON next edge and decrement `pending`.
  - An `in` pulse in the same cycle is not used to start the blink. It only increments `pending`.
- ON:
  - `out`=1.
  - Timer increments on each `en`.
  - On an `en` cycle with timer = `ON_TICKS`−1, go to GAP and clear the timer.
- GAP:
  - `out`=0.
  - Timer increments on each `en`.
  - On an `en` cycle with timer = `OFF_TICKS`−1, go to IDLE and clear the timer.
- Pending counter:
  - +1 on `in`, −1 when IDLE moves to ON.
  - If both happen in the same cycle, the net change is 0.
  - If `in`=1 with `pending` at maximum and no decrement that cycle, `pending` stays at maximum and `overflow` is set.
- `en`=0 freezes the timer only. The IDLE→ON transition and the pending counter are independent of `en`.
- `out` and `busy` are Moore decodes of the state register. They have no combinational path from `in`.

## Timing
- Reset values: state=IDLE, timer=0, `pending`=0, `overflow`=0, `out`=0, `busy`=0.
- Latency: `in` sampled at edge k gives `pending`=1 after edge k, and `out`=1 after edge k+1.
- With `en` tied to 1:
  - `out` stays high for exactly `ON_TICKS` cycles, then low for `OFF_TICKS` cycles of GAP plus 1 cycle of IDLE.
  - Back-to-back blink period is `ON_TICKS`+`OFF_TICKS`+1 cycles.
- Reset asserted mid-blink: `out`=0 and `pending`=0 after that edge. Queued events are discarded.
- The timer never wraps, because the terminal compare always fires before 2^`CNT_WIDTH`.

## Structure
- Shared package holds the state encodings (IDLE/ON/GAP) and the default tick constants.
- State register and timer use the existing `d_ff_re` register, with `r` driven by `~reset`.
- The pending counter with saturation and the overflow flag stay inline.
- No other sub-module.

## Test plan
All scenarios use the default parameters and `en`=1 unless noted.
- **Reset:** hold `reset`=0 for 2 cycles with `in` toggling. Then `out`=0, `busy`=0, `pending`=0, `overflow`=0.
- **Single event:** one `in` pulse at edge 10.
  - `pending`=1 after edge 10; `out`=1 from edge 11 to 15 (4 cycles).
  - `out`=0 for 4 cycles, `busy` falls after edge 18, `pending` returns to 0.
- **Burst of 3:** `in`=1 for 3 consecutive cycles.
  - `pending` sequence is 1,1,2, then decrements once per blink.
  - Exactly 3 blinks, each 4 high / 4 low; `overflow`=0.
- **Burst of 5:**
  - `pending` sequence is 1,1,2,3,3; `overflow`=1 after the 5th pulse.
  - Exactly 4 blinks total; `overflow` stays 1 until reset.
- **Throttled tick:** `en` high one cycle in 4.
  - One event gives `out` high for 4 `en` strobes (16 cycles ±3).
  - Holding `en`=0 mid-ON keeps `out`=1 indefinitely.
- **Reset mid-blink:** 2 events queued, `reset`=0 during ON. After that edge `out`=0 and `pending`=0, and no further blinks occur.
